// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit engine. Takes bytes over a valid/ready
// handshake and shifts them onto an idle-high serial line, LSB first, as
// start + DATA_BITS + STOP_BITS frames.
// Optional build macro: UART_TX_PARITY_EN inserts a parity bit between the
// data and stop bits and adds the PARITY_ODD parameter (0 = even, 1 = odd).
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD   = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  // tx_done is registered, so it is raised one cycle before the last stop cycle
  localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0]  DATA_LAST   = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST   = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_reg;
  logic [BAUD_W-1:0]      baud_reg;
  logic [IDX_W-1:0]       bit_idx_reg;
  logic [DATA_BITS-1:0]   shreg_reg;
  logic                   line_reg;
  logic                   ready_reg;
  logic                   busy_reg;
  logic                   done_reg;
`ifdef UART_TX_PARITY_EN
  logic                   parity_reg;
`endif

  // Frame sequencer: every output is registered so the pad sees a glitch-free line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shreg_reg   <= '0;
      line_reg    <= 1'b1;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (tx_valid) begin
            // Start bit goes out on the accepting edge itself
            shreg_reg   <= tx_data;
            state_reg   <= S_START;
            line_reg    <= 1'b0;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b1;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        S_START: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= '0;
            state_reg <= S_DATA;
            line_reg  <= shreg_reg[0];
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= '0;
            shreg_reg <= shreg_reg >> 1;
            if (bit_idx_reg == DATA_LAST) begin
              bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
              state_reg   <= S_PARITY;
              line_reg    <= parity_reg;
`else
              state_reg   <= S_STOP;
              line_reg    <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              line_reg    <= shreg_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= '0;
            state_reg <= S_STOP;
            line_reg  <= 1'b1;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // bit_idx_reg is reused to count stop bits
          if (baud_reg == BAUD_PENULT && bit_idx_reg == STOP_LAST) begin
            done_reg <= 1'b1;
          end
          if (baud_reg == BAUD_LAST) begin
            baud_reg <= '0;
            if (bit_idx_reg == STOP_LAST) begin
              bit_idx_reg <= '0;
              state_reg   <= S_IDLE;
              line_reg    <= 1'b1;
              ready_reg   <= 1'b1;
              busy_reg    <= 1'b0;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          line_reg  <= 1'b1;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready      = ready_reg;
  assign tx_serial_out = line_reg;
  assign tx_busy       = busy_reg;
  assign tx_done       = done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed bench for uart_tx_serializer with a
// frame-level expectation queue checked on every falling clock edge.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB         = 1;
  localparam int EXP_DONE   = 44;
  localparam int EXP_PERIOD = 45;
`else
  localparam int PB         = 0;
  localparam int EXP_DONE   = 40;
  localparam int EXP_PERIOD = 41;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_serial_out, tx_busy, tx_done;
  logic       odd_line;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_count = 0;
  int prev_rise = 0;
  int last_rise = 0;
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(DB),
    .STOP_BITS(SB)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD(0)
`endif
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tx_serial_out(tx_serial_out),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

`ifdef UART_TX_PARITY_EN
  logic odd_ready, odd_busy, odd_done;
  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(DB),
    .STOP_BITS(SB),
    .PARITY_ODD(1)
  ) u_dut_odd (
    .clk(clk),
    .rst_n(rst_n),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(odd_ready),
    .tx_serial_out(odd_line),
    .tx_busy(odd_busy),
    .tx_done(odd_done)
  );
`else
  assign odd_line = 1'b1;
`endif

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs per cycle, packed as {line, busy, ready, done}
  typedef struct packed {
    logic line;
    logic busy;
    logic ready;
    logic done;
  } exp_t;

  localparam exp_t IDLE_EXP = exp_t'(4'b1010);
  exp_t exp_q[$];

  // Build the whole frame as a list of line levels, each held CPB cycles
  task automatic push_frame(input logic [7:0] d);
    logic lvl[$];
    lvl.push_back(1'b0);
    for (int i = 0; i < DB; i++) lvl.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    lvl.push_back(($countones(d) % 2) == 1);
`endif
    for (int i = 0; i < SB; i++) lvl.push_back(1'b1);
    for (int b = 0; b < lvl.size(); b++) begin
      for (int c = 0; c < CPB; c++) begin
        exp_t e;
        e.line  = lvl[b];
        e.busy  = 1'b1;
        e.ready = 1'b0;
        e.done  = (b == lvl.size() - 1) && (c == CPB - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Cycle-by-cycle compare against the frame model
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      e = IDLE_EXP;
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
    end else begin
      e = IDLE_EXP;
    end
    check("model_cycle", int'({tx_serial_out, tx_busy, tx_ready, tx_done}), int'(e));
    if (rst_n && tx_valid && tx_ready) push_frame(tx_data);
  end

  // Event monitor: tx_done pulses and frame starts (busy rising)
  always @(negedge clk) begin
    if (tx_done) done_count++;
    if (tx_busy && !busy_prev) begin
      prev_rise = last_rise;
      last_rise = cyc;
    end
    busy_prev = tx_busy;
  end

  task automatic wait_ready(input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (!tx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!tx_ready) begin
      tests++;
      fails++;
      $display("FAIL %s: tx_ready timeout, got 0, required 1", name);
    end
  endtask

  // Called in cycle 1 after acceptance; samples each bit mid-way
  task automatic capture(output logic [11:0] bits, output logic [11:0] obits,
                         output int done_at, output int ready_at, output int ones,
                         input bit mid_change, input logic [7:0] mid_data);
    bits = '0;
    obits = '0;
    done_at = 0;
    ready_at = 0;
    ones = 0;
    for (int k = 1; k <= 60 && ready_at == 0; k++) begin
      @(negedge clk);
      if ((k % CPB) == 2 && (k / CPB) < 12) begin
        bits[k / CPB]  = tx_serial_out;
        obits[k / CPB] = odd_line;
      end
      if (k > CPB && k <= CPB * (DB + 1) && tx_serial_out) ones++;
      if (tx_done && done_at == 0) done_at = k;
      if (tx_ready) ready_at = k;
      if (mid_change && k == 12) begin
        tx_valid = 1'b1;
        tx_data  = mid_data;
      end
    end
    if (ready_at == 0) begin
      tests++;
      fails++;
      $display("FAIL capture: frame end timeout, got 0, required %0d", EXP_PERIOD);
    end
  endtask

  task automatic send(input logic [7:0] d, output logic [11:0] bits, output logic [11:0] obits,
                      output int done_at, output int ready_at, output int ones,
                      input bit mid_change, input logic [7:0] mid_data);
    @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = d;
    wait_ready("send");
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    capture(bits, obits, done_at, ready_at, ones, mid_change, mid_data);
    $display("[TB] frame 0x%02h bits=%03h done_at=%0d ready_at=%0d", d, bits, done_at, ready_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] bits, obits;
    int done_at, ready_at, ones, t0, t1, dc;

    // 1. Reset: held 3 cycles
    #1 rst_n = 1'b0;
    #1;
    check("reset_line", int'(tx_serial_out), 1);
    check("reset_ready", int'(tx_ready), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", int'(tx_busy), 0);
    check("post_reset_done", int'(tx_done), 0);
    $display("[TB] reset released at cycle %0d", cyc);

    // 2. Single byte 0xA5
    send(8'hA5, bits, obits, done_at, ready_at, ones, 1'b0, 8'h00);
    check("a5_start_data", int'(bits[8:0]), int'(9'b101001010));
    check("a5_stop", int'(bits[9+PB]), 1);
    check("a5_done_cycle", done_at, EXP_DONE);
    check("a5_ready_cycle", ready_at, EXP_DONE + 1);

    // 3. Back-to-back 0x00 then 0xFF with tx_valid held
    @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    wait_ready("b2b_first");
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    t0 = cyc;
    wait_ready("b2b_second");
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    t1 = cyc;
    capture(bits, obits, done_at, ready_at, ones, 1'b0, 8'h00);
    $display("[TB] back-to-back 0x00/0xFF accepted %0d cycles apart, bits=%03h", t1 - t0, bits);
    check("b2b_accept_gap", t1 - t0, EXP_PERIOD);
    check("b2b_start_gap", last_rise - prev_rise, EXP_PERIOD);
    check("ff_start_data", int'(bits[8:0]), int'(9'b111111110));
    check("ff_ones", ones, 32);
    check("ff_stop", int'(bits[9+PB]), 1);

    // 4. Busy stall: 0x3C presented (and held valid) mid-frame of 0x81
    send(8'h81, bits, obits, done_at, ready_at, ones, 1'b1, 8'h3C);
    check("stall_81_data", int'(bits[8:0]), int'(9'b100000010));
    check("stall_81_done", done_at, EXP_DONE);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    capture(bits, obits, done_at, ready_at, ones, 1'b0, 8'h00);
    $display("[TB] frame 0x3c bits=%03h done_at=%0d ready_at=%0d", bits, done_at, ready_at);
    check("stall_3c_data", int'(bits[8:0]), int'(9'b001111000));
    check("stall_3c_ready", ready_at, EXP_DONE + 1);

    // 5. Reset during data bit 3 of 0x55
    @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    wait_ready("rst_mid");
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    check("rst_mid_bit3_level", int'(tx_serial_out), 0);
    dc = done_count;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_line", int'(tx_serial_out), 1);
    check("rst_mid_busy", int'(tx_busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_mid_no_done", done_count, dc);
    $display("[TB] reset mid-frame of 0x55 at cycle %0d", cyc);
    send(8'h55, bits, obits, done_at, ready_at, ones, 1'b0, 8'h00);
    check("rst_after_55_data", int'(bits[8:0]), int'(9'b010101010));
    check("rst_after_55_stop", int'(bits[9+PB]), 1);
    check("rst_after_55_done", done_at, EXP_DONE);

`ifdef UART_TX_PARITY_EN
    // 6. Parity on 0x07 (three ones)
    send(8'h07, bits, obits, done_at, ready_at, ones, 1'b0, 8'h00);
    check("par_data", int'(bits[8:0]), int'(9'b000001110));
    check("par_even_bit", int'(bits[9]), 1);
    check("par_odd_bit", int'(obits[9]), 0);
    check("par_stop", int'(bits[10]), 1);
    check("par_done_cycle", done_at, 44);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
